// File: rtl/reg_bank_irq.sv
// Register bank with config, sampled status, W1C event capture, mask and registered irq.
// Define REG_BANK_STATUS_SYNC_EN to put a 2-flop synchronizer in front of the status sampler.
module reg_bank_irq #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_W     = 5,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             ena,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [REG_WIDTH-1:0]             wdata,
  input  logic                             we,
  input  logic                             re,
  output logic [REG_WIDTH-1:0]             rdata,
  output logic                             rvalid,
  output logic                             addr_err,
  output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
  output logic                             irq
);

  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_CFG);
  localparam logic [ADDR_W-1:0] A_EVT  = ADDR_W'(NUM_CFG + NUM_STATUS);
  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(NUM_CFG + NUM_STATUS + 1);

  logic [REG_WIDTH-1:0]  cfg_q    [NUM_CFG];
  logic [REG_WIDTH-1:0]  status_q [NUM_STATUS];
  logic [NUM_STATUS-1:0] evt_q;
  logic [NUM_STATUS-1:0] mask_q;
  logic [NUM_STATUS-1:0] evt_set;
  logic [NUM_STATUS-1:0] evt_clr;
  logic [NUM_STATUS-1:0] chg;
  logic [1:0]            prime_q;

  logic                  wr_en;
  logic                  rd_en;
  logic                  hit_evt;
  logic                  hit_mask;
  logic                  unmapped;
  logic [REG_WIDTH-1:0]  rd_mux;

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
    assign config_regs[k*REG_WIDTH +: REG_WIDTH] = cfg_q[k];
  end

  // Stage p0: status sampling; chg compares the newest sample with the one before it
`ifdef REG_BANK_STATUS_SYNC_EN
  localparam logic [1:0] PRIME = 2'd3;
  logic [REG_WIDTH-1:0] sync_p0 [NUM_STATUS];
  logic [REG_WIDTH-1:0] sync_p1 [NUM_STATUS];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NUM_STATUS; i++) begin
        sync_p0[i]  <= '0;
        sync_p1[i]  <= '0;
        status_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STATUS; i++) begin
        sync_p0[i]  <= status_regs[i*REG_WIDTH +: REG_WIDTH];
        sync_p1[i]  <= sync_p0[i];
        status_q[i] <= sync_p1[i];
      end
    end
  end

  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_STATUS; i++) chg[i] = (sync_p1[i] != status_q[i]);
  end
`else
  localparam logic [1:0] PRIME = 2'd2;
  logic [REG_WIDTH-1:0] status_d [NUM_STATUS];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NUM_STATUS; i++) begin
        status_q[i] <= '0;
        status_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STATUS; i++) begin
        status_q[i] <= status_regs[i*REG_WIDTH +: REG_WIDTH];
        status_d[i] <= status_q[i];
      end
    end
  end

  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_STATUS; i++) chg[i] = (status_q[i] != status_d[i]);
  end
`endif

  // Decode; a write in the same cycle as a read takes priority and the read is dropped
  always_comb begin
    wr_en    = we & ena;
    rd_en    = re & ena & ~we;
    hit_evt  = (addr == A_EVT);
    hit_mask = (addr == A_MASK);
    unmapped = (addr > A_MASK);
    evt_clr  = (wr_en && hit_evt) ? wdata[NUM_STATUS-1:0] : '0;
    evt_set  = (prime_q == PRIME) ? chg : '0;
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (addr == ADDR_W'(k)) rd_mux = cfg_q[k];
    for (int i = 0; i < NUM_STATUS; i++)
      if (addr == ADDR_W'(NUM_CFG + i)) rd_mux = status_q[i];
    if (hit_evt)  rd_mux = REG_WIDTH'(evt_q);
    if (hit_mask) rd_mux = REG_WIDTH'(mask_q);
  end

  // Stage p1: register updates and registered read / irq outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= CFG_RESET[k*REG_WIDTH +: REG_WIDTH];
      evt_q    <= '0;
      mask_q   <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
      irq      <= 1'b0;
      prime_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_CFG; k++)
        if (wr_en && addr == ADDR_W'(k)) cfg_q[k] <= wdata;
      if (wr_en && hit_mask) mask_q <= wdata[NUM_STATUS-1:0];
      evt_q    <= (evt_q & ~evt_clr) | evt_set;
      rvalid   <= rd_en;
      if (rd_en) rdata <= rd_mux;
      addr_err <= (wr_en | rd_en) & unmapped;
      irq      <= |(evt_q & mask_q);
      if (prime_q != PRIME) prime_q <= prime_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_reg_bank_irq.sv
// Scoreboard bench for reg_bank_irq: read expectations are queued, a monitor thread checks rvalid beats.
module tb_reg_bank_irq;

`ifdef REG_BANK_STATUS_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic        ena_a, we_a, re_a, rvalid_a, addr_err_a, irq_a;
  logic [4:0]  addr_a;
  logic [7:0]  wdata_a, rdata_a;
  logic [63:0] cfg_a, stat_a;

  logic        ena_b, we_b, re_b, rvalid_b, addr_err_b, irq_b;
  logic [3:0]  addr_b;
  logic [7:0]  wdata_b, rdata_b;
  logic [31:0] cfg_b;
  logic [23:0] stat_b;

  reg_bank_irq #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8), .ADDR_W(5),
                 .CFG_RESET({8{8'hA5}})) dut_a (
    .clk(clk), .rstb(rstb), .ena(ena_a), .addr(addr_a), .wdata(wdata_a),
    .we(we_a), .re(re_a), .rdata(rdata_a), .rvalid(rvalid_a),
    .addr_err(addr_err_a), .config_regs(cfg_a), .status_regs(stat_a), .irq(irq_a));

  reg_bank_irq #(.NUM_CFG(4), .NUM_STATUS(3), .REG_WIDTH(8), .ADDR_W(4),
                 .CFG_RESET(32'h44332211)) dut_b (
    .clk(clk), .rstb(rstb), .ena(ena_b), .addr(addr_b), .wdata(wdata_b),
    .we(we_b), .re(re_b), .rdata(rdata_b), .rvalid(rvalid_b),
    .addr_err(addr_err_b), .config_regs(cfg_b), .status_regs(stat_b), .irq(irq_b));

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rvalid_a) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL rvalid_a: got 1 expected 0");
        end else begin
          exp_t x;
          x = qa.pop_front();
          chk("rdata_a", rdata_a, x.d);
          chk("rd_addr_err_a", addr_err_a, x.e);
        end
      end
      if (rvalid_b) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rvalid_b: got 1 expected 0");
        end else begin
          exp_t x;
          x = qb.pop_front();
          chk("rdata_b", rdata_b, x.d);
          chk("rd_addr_err_b", addr_err_b, x.e);
        end
      end
    end
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_a = a; wdata_a = d; we_a = 1'b1;
    @(negedge clk);
    we_a = 1'b0;
  endtask

  task automatic rd_a(input logic [4:0] a, input logic [7:0] d, input logic e);
    exp_t x;
    @(negedge clk);
    addr_a = a; re_a = 1'b1;
    x.d = d; x.e = e;
    qa.push_back(x);
    @(negedge clk);
    re_a = 1'b0;
  endtask

  task automatic wrrd_a(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_a = a; wdata_a = d; we_a = 1'b1; re_a = 1'b1;
    @(negedge clk);
    we_a = 1'b0; re_a = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [7:0] d, input logic en);
    @(negedge clk);
    addr_b = a; wdata_b = d; we_b = 1'b1; ena_b = en;
    @(negedge clk);
    we_b = 1'b0; ena_b = 1'b1;
  endtask

  task automatic rd_b(input logic [3:0] a, input logic [7:0] d, input logic e, input logic en);
    exp_t x;
    @(negedge clk);
    addr_b = a; re_b = 1'b1; ena_b = en;
    if (en) begin
      x.d = d; x.e = e;
      qb.push_back(x);
    end
    @(negedge clk);
    re_b = 1'b0; ena_b = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      monitor();
    join_none
    rstb = 1'b0;
    ena_a = 1'b1; we_a = 1'b0; re_a = 1'b0; addr_a = '0; wdata_a = '0; stat_a = '0;
    ena_b = 1'b1; we_b = 1'b0; re_b = 1'b0; addr_b = '0; wdata_b = '0; stat_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_cfg_a", cfg_a, {8{8'hA5}});
    chk("rst_cfg_b", cfg_b, 32'h44332211);
    chk("rst_rdata_a", rdata_a, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_addr_err_a", addr_err_a, 0);
    chk("rst_irq_a", irq_a, 0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 8; k++) rd_a(5'(k), 8'hA5, 1'b0);
    rd_a(5'd16, 8'h00, 1'b0);
    rd_a(5'd17, 8'h00, 1'b0);
    chk("idle_irq_a", irq_a, 0);

    wr_a(5'd3, 8'h3C);
    chk("cfg3_write", cfg_a[31:24], 8'h3C);
    chk("cfg2_untouched", cfg_a[23:16], 8'hA5);
    rd_a(5'd3, 8'h3C, 1'b0);
    wr_a(5'd9, 8'h55);
    chk("status_write_err", addr_err_a, 0);
    chk("status_write_cfg", cfg_a, 64'hA5A5A5A5_3CA5A5A5);
    rd_a(5'd9, 8'h00, 1'b0);

    // masked event on status slice 1
    wr_a(5'd17, 8'h02);
    @(negedge clk);
    stat_a[15:8] = 8'h7E;
    repeat (LAT) @(negedge clk);
    chk("irq_before_rise", irq_a, 0);
    @(negedge clk);
    chk("irq_rise", irq_a, 1);
    rd_a(5'd16, 8'h02, 1'b0);
    rd_a(5'd9, 8'h7E, 1'b0);
    rd_a(5'd17, 8'h02, 1'b0);
    wr_a(5'd16, 8'h02);
    chk("irq_hold_after_w1c", irq_a, 1);
    @(negedge clk);
    chk("irq_fall", irq_a, 0);
    rd_a(5'd16, 8'h00, 1'b0);

    // two events with everything masked, then unmask bit 0
    wr_a(5'd17, 8'h00);
    @(negedge clk);
    stat_a[7:0] = 8'h11; stat_a[15:8] = 8'h22;
    repeat (LAT + 2) @(negedge clk);
    chk("irq_masked", irq_a, 0);
    rd_a(5'd16, 8'h03, 1'b0);
    wr_a(5'd17, 8'h01);
    chk("irq_unmask_lag", irq_a, 0);
    @(negedge clk);
    chk("irq_unmask", irq_a, 1);

    // W1C of bit 0 on the same edge a new bit-0 event lands
    @(negedge clk);
    stat_a[7:0] = 8'h33;
    repeat (LAT - 2) @(negedge clk);
    wr_a(5'd16, 8'h01);
    rd_a(5'd16, 8'h03, 1'b0);
    chk("irq_after_collision", irq_a, 1);

    // simultaneous write and read: write lands, no rvalid
    wrrd_a(5'd5, 8'h5A);
    chk("wr_rd_cfg5", cfg_a[47:40], 8'h5A);
    rd_a(5'd5, 8'h5A, 1'b0);

    // small configuration: unmapped and disabled accesses
    rd_b(4'd0, 8'h11, 1'b0, 1'b1);
    rd_b(4'd15, 8'h00, 1'b1, 1'b1);
    rd_b(4'd1, 8'h22, 1'b0, 1'b1);
    wr_b(4'd0, 8'hFF, 1'b0);
    chk("dis_wr_cfg_b", cfg_b, 32'h44332211);
    chk("dis_wr_err_b", addr_err_b, 0);
    rd_b(4'd15, 8'h00, 1'b0, 1'b0);
    chk("dis_rd_err_b", addr_err_b, 0);
    chk("dis_rd_hold_b", rdata_b, 8'h22);
    wr_b(4'd12, 8'hAA, 1'b1);
    chk("unmapped_wr_err_b", addr_err_b, 1);
    @(negedge clk);
    chk("unmapped_err_pulse_b", addr_err_b, 0);
    wr_b(4'd2, 8'h77, 1'b1);
    chk("cfg2_write_b", cfg_b, 32'h44772211);

    repeat (3) @(negedge clk);
    chk("queue_a_drained", 64'(qa.size()), 0);
    chk("queue_b_drained", 64'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
